// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one imem port between the fetch
// stage (read-only) and the loader/debug port (read/write). One transaction
// is in flight at a time; killed fetches run to completion silently, and a
// starvation counter lets fetch win a contention after STARVE_MAX loader wins.
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_kill,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              load_req,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_done,
  output logic [DATA_W-1:0] load_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              loader_owns
);

  typedef enum logic [1:0] {IDLE, FETCH_BUSY, LOAD_BUSY} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       killed, killed_nxt;
  logic       fetch_ok, fetch_win, load_win, busy_done;

  // Arbitration in IDLE: loader wins contention until fetch has been starved
  // STARVE_MAX times; a fetch being killed this cycle is never granted.
  always_comb begin
    fetch_ok  = fetch_req & ~fetch_kill;
    fetch_win = (state == IDLE) & fetch_ok & (~load_req | (starve_cnt == SMAX));
    load_win  = (state == IDLE) & load_req & ~fetch_win;
    busy_done = (state != IDLE) & mem_ready;
  end

  // Next state, starvation counter and kill tracking.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    killed_nxt = killed;
    case (state)
      IDLE: begin
        if (load_win) begin
          state_nxt = LOAD_BUSY;
          if (fetch_req && starve_cnt != SMAX) starve_nxt = starve_cnt + 4'd1;
        end else if (fetch_win) begin
          state_nxt  = FETCH_BUSY;
          starve_nxt = 4'd0;
        end
      end
      FETCH_BUSY: begin
        if (mem_ready) begin
          state_nxt  = IDLE;
          killed_nxt = 1'b0;
        end else if (fetch_kill) begin
          killed_nxt = 1'b1;
        end
      end
      LOAD_BUSY: begin
        if (mem_ready) begin
          state_nxt  = IDLE;
          killed_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      killed     <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      killed     <= killed_nxt;
    end
  end

  // Memory request registers: captured from the winner at grant, so the
  // mem_* outputs never depend combinationally on mem_rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (fetch_win) begin
      mem_we    <= 1'b0;
      mem_addr  <= fetch_addr;
      mem_wdata <= '0;
    end else if (load_win) begin
      mem_we    <= load_we;
      mem_addr  <= load_addr;
      mem_wdata <= load_wdata;
    end else if (busy_done) begin
      mem_we    <= 1'b0;
    end
  end

  assign mem_req     = (state != IDLE);
  assign fetch_done  = (state == FETCH_BUSY) & mem_ready & ~killed & ~fetch_kill;
  assign fetch_rdata = mem_rdata;
  assign load_done   = (state == LOAD_BUSY) & mem_ready;
  assign load_rdata  = mem_rdata;
  // Held low during reset so the PC is never frozen by a stale load_req.
  assign loader_owns = reset_n & ((state == LOAD_BUSY) | load_win);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_imem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_req, fetch_kill, fetch_done;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_rdata;
  logic          load_req, load_we, load_done;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_wdata, load_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          loader_owns;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_kill(fetch_kill),
    .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_done(load_done), .load_rdata(load_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .loader_owns(loader_owns)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory contents and response timing
  logic [31:0] marr [0:255];
  int bcnt = 0, lat_cur = 1, lat_fixed = 0;

  // reference model: who owns the port and what it asked for
  int          m_own = 0;           // 0 none, 1 fetch, 2 loader
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic        m_we = 0, m_killed = 0;
  int          m_starve = 0;

  // values seen in the last checked cycle
  logic        s_req, s_ready, s_fd, s_ld, s_lo, s_we;
  logic [31:0] s_frd, s_lrd, s_addr, s_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge: respond as memory,
  // check outputs against the model, then advance the model across the edge.
  task automatic tick();
    logic        f_ok, fgrant, lgrant, e_fd, e_ld, e_lo, wr_pend;
    logic [7:0]  wr_a;
    logic [31:0] wr_d;
    if (mem_req === 1'b1) begin
      if (bcnt == 0) lat_cur = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
      bcnt++;
      mem_ready = (bcnt >= lat_cur);
    end else begin
      bcnt      = 0;
      mem_ready = 1'b0;
    end
    mem_rdata = mem_ready ? marr[mem_addr[7:0]] : $urandom;
    #1;
    f_ok   = fetch_req & ~fetch_kill;
    fgrant = (m_own == 0) && f_ok && (!load_req || m_starve == SM);
    lgrant = (m_own == 0) && load_req && !fgrant;
    e_fd   = (m_own == 1) && mem_ready && !m_killed && !fetch_kill;
    e_ld   = (m_own == 2) && mem_ready;
    e_lo   = (m_own == 2) || lgrant;
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_own != 0});
    if (m_own != 0) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, (m_own == 2) && m_we});
      chk("mem_addr", mem_addr, m_addr);
      if (m_own == 2 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("fetch_done", {31'd0, fetch_done}, {31'd0, e_fd});
    chk("load_done", {31'd0, load_done}, {31'd0, e_ld});
    chk("loader_owns", {31'd0, loader_owns}, {31'd0, e_lo});
    if (e_fd) chk("fetch_rdata", fetch_rdata, marr[m_addr[7:0]]);
    if (e_ld && !m_we) chk("load_rdata", load_rdata, marr[m_addr[7:0]]);
    s_req = mem_req; s_ready = mem_ready; s_fd = fetch_done; s_ld = load_done;
    s_lo = loader_owns; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
    s_frd = fetch_rdata; s_lrd = load_rdata;
    wr_pend = mem_req && mem_we && mem_ready;
    wr_a = mem_addr[7:0];
    wr_d = mem_wdata;
    @(posedge clk);
    if (wr_pend) marr[wr_a] = wr_d;
    if (m_own == 0) begin
      if (lgrant) begin
        m_own = 2; m_we = load_we; m_addr = load_addr; m_wdata = load_wdata;
        if (fetch_req && m_starve < SM) m_starve++;
      end else if (fgrant) begin
        m_own = 1; m_we = 1'b0; m_addr = fetch_addr; m_starve = 0;
      end
    end else if (mem_ready) begin
      m_own = 0; m_killed = 1'b0;
    end else if (m_own == 1 && fetch_kill) begin
      m_killed = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int   reqc, fdc, ldc, lo_bad, g;
    logic [31:0] rd;
    logic got_f [0:9];

    for (int i = 0; i < 256; i++) marr[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    reset_n = 1'b0;
    fetch_req = 0; fetch_kill = 0; fetch_addr = 0;
    load_req = 0; load_we = 0; load_addr = 0; load_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_fetch_done", {31'd0, fetch_done}, 0);
    chk("rst_load_done", {31'd0, load_done}, 0);
    chk("rst_loader_owns", {31'd0, loader_owns}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // fetch only, two-cycle memory
    marr[8'h10] = 32'hDEADBEEF;
    lat_fixed = 2; fetch_req = 1; fetch_addr = 32'h10;
    reqc = 0; fdc = 0; rd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_req) begin
        reqc++;
        chk("t1_we", {31'd0, s_we}, 0);
        chk("t1_addr", s_addr, 32'h10);
      end
      if (s_fd) begin fdc++; rd = s_frd; fetch_req = 0; end
    end
    chk("t1_req_cycles", reqc, 2);
    chk("t1_done_pulses", fdc, 1);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_idle", {31'd0, mem_req}, 0);

    // loader write then read back
    lat_fixed = 1;
    for (int pass = 0; pass < 2; pass++) begin
      load_req = 1; load_we = (pass == 0); load_addr = 32'h20; load_wdata = 32'h12345678;
      ldc = 0; lo_bad = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (load_req && !s_lo) lo_bad++;
        if (s_ld) begin
          ldc++;
          chk("t2_we", {31'd0, s_we}, {31'd0, pass == 0});
          if (pass == 0) chk("t2_wdata", s_wd, 32'h12345678);
          else chk("t2_rdata", s_lrd, 32'h12345678);
          load_req = 0;
        end
      end
      chk("t2_done_pulses", ldc, 1);
      chk("t2_owns_gap", lo_bad, 0);
    end

    // contention with both held: grant order L,L,L,L,F,...
    lat_fixed = 1;
    fetch_req = 1; fetch_addr = 32'h30;
    load_req = 1; load_we = 0; load_addr = 32'h34;
    g = 0;
    for (int i = 0; i < 60 && g < 10; i++) begin
      tick();
      if (s_fd) begin got_f[g] = 1'b1; g++; end
      else if (s_ld) begin got_f[g] = 1'b0; g++; end
    end
    chk("t3_grants", g, 10);
    for (int k = 0; k < g; k++) chk("t3_order", {31'd0, got_f[k]}, {31'd0, (k % 5) == 4});
    fetch_req = 0; load_req = 0;
    tick(); tick();

    // kill one cycle after grant; memory still completes
    lat_fixed = 3; fetch_req = 1; fetch_addr = 32'h3C;
    tick();
    fetch_kill = 1;
    tick();
    fetch_kill = 0; fetch_req = 0; fdc = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (s_fd) fdc++; end
    chk("t4_no_done", fdc, 0);
    chk("t4_idle", {31'd0, mem_req}, 0);
    marr[8'h40] = 32'hCAFE_F00D;
    lat_fixed = 1; fetch_req = 1; fetch_addr = 32'h40; fdc = 0; rd = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_fd) begin fdc++; rd = s_frd; fetch_req = 0; end
    end
    chk("t4_refetch_done", fdc, 1);
    chk("t4_refetch_rdata", rd, 32'hCAFE_F00D);

    // kill coincident with mem_ready
    lat_fixed = 2; fetch_req = 1; fetch_addr = 32'h44;
    tick(); tick();
    fetch_kill = 1;
    tick();
    chk("t5_ready", {31'd0, s_ready}, 1);
    chk("t5_no_done", {31'd0, s_fd}, 0);
    fetch_kill = 0; fetch_req = 0;
    tick();
    chk("t5_idle", {31'd0, mem_req}, 0);

    // async reset in the middle of a loader write
    lat_fixed = 4;
    fetch_req = 1; fetch_addr = 32'h10;
    load_req = 1; load_we = 1; load_addr = 32'h50; load_wdata = 32'h0BAD_0BAD;
    tick(); tick();
    chk("t6_pre_starve", {28'd0, dut.starve_cnt}, 1);
    #2 reset_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("t6_mem_req", {31'd0, mem_req}, 0);
    chk("t6_mem_we", {31'd0, mem_we}, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_fetch_done", {31'd0, fetch_done}, 0);
    chk("t6_load_done", {31'd0, load_done}, 0);
    chk("t6_loader_owns", {31'd0, loader_owns}, 0);
    chk("t6_starve", {28'd0, dut.starve_cnt}, 0);
    m_own = 0; m_killed = 0; m_starve = 0; bcnt = 0;
    load_req = 0;
    @(negedge clk);
    reset_n = 1'b1;
    lat_fixed = 1; fdc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_fd) begin fdc++; fetch_req = 0; end
    end
    chk("t6_fetch_after", fdc, 1);
    chk("t6_starve_after", {28'd0, dut.starve_cnt}, 0);
    chk("t6_marr_untouched", marr[8'h50], 32'hA5A5_0000 ^ (32'h50 * 32'h0101_0101));

    // random traffic with random memory latency
    lat_fixed = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!fetch_req && $urandom_range(0, 2) == 0) begin
        fetch_req = 1; fetch_addr = $urandom_range(0, 63);
      end
      fetch_kill = fetch_req && ($urandom_range(0, 9) == 0);
      if (!load_req && $urandom_range(0, 3) == 0) begin
        load_req = 1; load_we = $urandom_range(0, 1);
        load_addr = $urandom_range(0, 63); load_wdata = $urandom;
      end
      tick();
      if (s_fd || fetch_kill) fetch_req = 0;
      fetch_kill = 0;
      if (s_ld) load_req = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
